// File: rtl/majority_bit_tx.sv
// Oversampling framed serial transmitter: start, LSB-first data, optional even parity, stop.
// Each line bit is held SAMPLES_PER_BIT clocks. Define MAJORITY_BIT_TX_PARITY_EN for the parity bit.
module majority_bit_tx #(
    parameter int   DATA_WIDTH      = 8,
    parameter int   SAMPLES_PER_BIT = 8,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  bit_out,
    output logic                  busy
);

    localparam int SMP_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef MAJORITY_BIT_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t                r_state;
    logic [SMP_W-1:0]      r_smp;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_bitOut;

    state_t                w_stateNext;
    logic [SMP_W-1:0]      w_smpNext;
    logic [IDX_W-1:0]      w_idxNext;
    logic [DATA_WIDTH-1:0] w_shregNext;
    logic                  w_bitNext;
    logic                  w_last;
    logic                  w_accept;

`ifdef MAJORITY_BIT_TX_PARITY_EN
    logic                  r_par;
    logic                  w_parNext;
`endif

    assign w_last   = (r_smp == SMP_LAST);
    assign s_ready  = !rst && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_last));
    assign w_accept = s_valid && s_ready;
    assign busy     = (r_state != ST_IDLE);
    assign bit_out  = r_bitOut;

    always_comb begin
        w_stateNext = r_state;
        w_smpNext   = w_last ? '0 : r_smp + SMP_W'(1);
        w_idxNext   = r_idx;
        w_shregNext = r_shreg;
`ifdef MAJORITY_BIT_TX_PARITY_EN
        w_parNext   = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                w_smpNext = '0;
                if (w_accept) begin
                    w_stateNext = ST_START;
                    w_shregNext = s_data;
`ifdef MAJORITY_BIT_TX_PARITY_EN
                    w_parNext   = ^s_data;
`endif
                end
            end
            ST_START: begin
                if (w_last) begin
                    w_stateNext = ST_DATA;
                    w_idxNext   = '0;
                end
            end
            ST_DATA: begin
                if (w_last) begin
                    w_shregNext = r_shreg >> 1;
                    w_idxNext   = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
                        w_idxNext   = '0;
`ifdef MAJORITY_BIT_TX_PARITY_EN
                        w_stateNext = ST_PARITY;
`else
                        w_stateNext = ST_STOP;
`endif
                    end
                end
            end
`ifdef MAJORITY_BIT_TX_PARITY_EN
            ST_PARITY: begin
                if (w_last) begin
                    w_stateNext = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_last) begin
                    // A word accepted on the final stop sample starts the next frame with no idle gap.
                    if (w_accept) begin
                        w_stateNext = ST_START;
                        w_shregNext = s_data;
`ifdef MAJORITY_BIT_TX_PARITY_EN
                        w_parNext   = ^s_data;
`endif
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_smpNext   = '0;
            end
        endcase
    end

    always_comb begin
        w_bitNext = IDLE_LEVEL;
        case (w_stateNext)
            ST_START:  w_bitNext = ~IDLE_LEVEL;
            ST_DATA:   w_bitNext = w_shregNext[0];
`ifdef MAJORITY_BIT_TX_PARITY_EN
            ST_PARITY: w_bitNext = w_parNext;
`endif
            default:   w_bitNext = IDLE_LEVEL;
        endcase
    end

    // The line bit is registered from next-state values so the pin never glitches on decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_smp    <= '0;
            r_idx    <= '0;
            r_shreg  <= '0;
            r_bitOut <= IDLE_LEVEL;
`ifdef MAJORITY_BIT_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_stateNext;
            r_smp    <= w_smpNext;
            r_idx    <= w_idxNext;
            r_shreg  <= w_shregNext;
            r_bitOut <= w_bitNext;
`ifdef MAJORITY_BIT_TX_PARITY_EN
            r_par    <= w_parNext;
`endif
        end
    end

endmodule

// File: tb/tb_majority_bit_tx.sv
// Self-checking bench for majority_bit_tx: scoreboard of expected line samples plus a
// majority-vote receiver with injected one-sample glitches. Honours MAJORITY_BIT_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_majority_bit_tx;

    localparam int   DW     = 8;
    localparam int   SPB    = 8;
    localparam logic IDLE   = 1'b1;
`ifdef MAJORITY_BIT_TX_PARITY_EN
    localparam int   NBITS  = DW + 3;
`else
    localparam int   NBITS  = DW + 2;
`endif
    localparam int   F      = SPB * NBITS;
    localparam int   THRESH = SPB / 2 + 1;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          bit_out;
    logic          busy;

    majority_bit_tx #(
        .DATA_WIDTH      (DW),
        .SAMPLES_PER_BIT (SPB),
        .IDLE_LEVEL      (IDLE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .bit_out (bit_out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic expQ[$];
    int   idxQ[$];
    int   acceptCycle[$];
    int   acceptCount = 0;
    int   busyTotal = 0;
    int   cycle = 0;
    int   ones = 0;
    logic rstPrev = 1'b0;
    logic glitchEn = 1'b0;
    logic expReady, expBusy, expBit, line;

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cycle);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cycle);
        end
    endtask

    task automatic pushBit(input logic b);
        for (int s = 0; s < SPB; s++) begin
            expQ.push_back(b);
            idxQ.push_back(s);
        end
    endtask

    task automatic pushFrame(input logic [DW-1:0] w);
        pushBit(~IDLE);
        for (int i = 0; i < DW; i++) pushBit(w[i]);
`ifdef MAJORITY_BIT_TX_PARITY_EN
        pushBit(^w);
`endif
        pushBit(IDLE);
    endtask

    // One scoreboard step per cycle, sampled on the falling edge.
    task automatic monitorStep();
        expReady = !rst && (expQ.size() <= 1);
        checkOutput("s_ready", s_ready, expReady);
        if (rst) begin
            if (rstPrev) begin
                checkOutput("rst_bit_out", bit_out, IDLE);
                checkOutput("rst_busy", busy, 1'b0);
            end
            expQ.delete();
            idxQ.delete();
            ones = 0;
        end else begin
            expBusy = (expQ.size() != 0);
            expBit  = expBusy ? expQ[0] : IDLE;
            checkOutput("bit_out", bit_out, expBit);
            checkOutput("busy", busy, expBusy);
            if (busy) busyTotal++;
            if (expBusy) begin
                line = bit_out ^ (glitchEn && (SPB >= 3) && (idxQ[0] == 2));
                ones += int'(line);
                if (idxQ[0] == SPB - 1) begin
                    checkOutput("loopback", logic'(ones >= THRESH), expQ[0]);
                    ones = 0;
                end
                void'(expQ.pop_front());
                void'(idxQ.pop_front());
            end
            if (s_valid && expReady) begin
                pushFrame(s_data);
                acceptCount++;
                acceptCycle.push_back(cycle);
            end
        end
        rstPrev = rst;
        cycle++;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic v);
        @(posedge clk);
        #1;
        s_data  = d;
        s_valid = v;
    endtask

    task automatic waitAccept(input int limit);
        int start;
        int n;
        start = acceptCount;
        n = 0;
        while (acceptCount == start && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (acceptCount == start) checkCount("accept_timeout", 0, 1);
        #1;
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0) checkCount("idle_timeout", expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int b0;
        int n;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        fork
            forever begin
                @(negedge clk);
                monitorStep();
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] single frame 0xA5 with s_data churn");
        b0 = busyTotal;
        applyStimulus(8'hA5, 1'b1);
        waitAccept(50);
        s_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 s_data = DW'($urandom);
        end
        waitIdle(2 * F);
        checkCount("busy_len_A5", busyTotal - b0, F);

        $display("[TB] stall 20 cycles");
        b0 = busyTotal;
        repeat (20) @(posedge clk);
        checkCount("stall_busy", busyTotal - b0, 0);

        $display("[TB] single frame 0x07");
        b0 = busyTotal;
        applyStimulus(8'h07, 1'b1);
        waitAccept(50);
        s_valid = 1'b0;
        waitIdle(2 * F);
        checkCount("busy_len_07", busyTotal - b0, F);

        $display("[TB] back-to-back 0x3C, 0xC3");
        applyStimulus(8'h3C, 1'b1);
        waitAccept(50);
        s_data = 8'hC3;
        waitAccept(2 * F);
        s_valid = 1'b0;
        n = acceptCycle.size();
        checkCount("b2b_spacing", acceptCycle[n-1] - acceptCycle[n-2], F);
        waitIdle(2 * F);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hE1, 1'b1);
        waitAccept(50);
        s_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3 * SPB) @(posedge clk);

        $display("[TB] loopback with glitches");
        glitchEn = 1'b1;
        applyStimulus(DW'($urandom), 1'b1);
        for (int f = 0; f < 3; f++) begin
            waitAccept(2 * F);
            s_data = DW'($urandom);
        end
        s_valid = 1'b0;
        waitIdle(2 * F);
        glitchEn = 1'b0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
